// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO controller sequencing a dual-port RAM as a circular buffer
// Optional sticky overflow/underflow flags enabled by defining FIFO_ERR_FLAG_EN.
module sync_fifo_ctrl #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [AW:0]      count,
    output logic             ram_wr_en,
    output logic [AW-1:0]    ram_wr_addr,
    output logic [WIDTH-1:0] ram_wr_data,
    output logic             ram_rd_en,
    output logic [AW-1:0]    ram_rd_addr,
    input  logic [WIDTH-1:0] ram_rd_data,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] AF_THR = AF_LEVEL[AW:0];

    logic [AW:0] wptr, rptr;
    logic [AW:0] wptr_nxt, rptr_nxt, count_nxt;
    logic        wr_acc, rd_acc;

    // Gating with rst keeps the RAM untouched while the controller is held in reset.
    assign wr_acc = push & ~full & ~rst;
    assign rd_acc = pop & ~empty & ~rst;

    assign ram_wr_en   = wr_acc;
    assign ram_wr_addr = wptr[AW-1:0];
    assign ram_wr_data = push_data;
    assign ram_rd_en   = rd_acc;
    assign ram_rd_addr = rptr[AW-1:0];
    assign pop_data    = ram_rd_data;

    always_comb begin
        wptr_nxt  = wptr + {{AW{1'b0}}, wr_acc};
        rptr_nxt  = rptr + {{AW{1'b0}}, rd_acc};
        count_nxt = wptr_nxt - rptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            pop_valid   <= 1'b0;
        end else begin
            wptr        <= wptr_nxt;
            rptr        <= rptr_nxt;
            count       <= count_nxt;
            full        <= (wptr_nxt[AW] != rptr_nxt[AW]) &&
                           (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
            empty       <= (wptr_nxt == rptr_nxt);
            almost_full <= (count_nxt >= AF_THR);
            pop_valid   <= rd_acc;
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    // A new error event takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push & full)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (pop & empty)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed self-checking bench for sync_fifo_ctrl with a registered-read RAM model
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       pop = 1'b0;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       full, empty, almost_full;
    logic [4:0] count;
    logic       ram_wr_en, ram_rd_en;
    logic [3:0] ram_wr_addr, ram_rd_addr;
    logic [7:0] ram_wr_data;
    logic [7:0] ram_rd_data = 8'h00;
    logic       err_clr = 1'b0;
    logic       overflow, underflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    sync_fifo_ctrl #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .err_clr(err_clr),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0)      begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (count !== 5'd0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL reset_pop_valid got=%b exp=0", pop_valid); end
        total++; if (ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0)
            begin bad++; $display("FAIL reset_ram_en got=%b%b exp=00", ram_wr_en, ram_rd_en); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin bad++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 16; i++) begin
            push = 1'b1;
            push_data = 8'(i);
            #1;
            total++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 4'(i))
                begin bad++; $display("FAIL fill_wr i=%0d got en=%b addr=%0d exp en=1 addr=%0d", i, ram_wr_en, ram_wr_addr, i); end
            tick();
            total++; if (count !== 5'(i + 1))
                begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
            total++; if (almost_full !== ((i + 1) >= 14))
                begin bad++; $display("FAIL fill_af count=%0d got=%b exp=%b", i + 1, almost_full, (i + 1) >= 14); end
            total++; if (full !== ((i + 1) == 16))
                begin bad++; $display("FAIL fill_full count=%0d got=%b exp=%b", i + 1, full, (i + 1) == 16); end
        end
        push_data = 8'hEE;
        #1;
        total++; if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL overpush_wr_en got=%b exp=0", ram_wr_en); end
        tick();
        push = 1'b0;
        total++; if (count !== 5'd16) begin bad++; $display("FAIL overpush_count got=%0d exp=16", count); end
`ifdef FIFO_ERR_FLAG_EN
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_set got=%b exp=1", overflow); end
`else
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_off got=%b exp=0", overflow); end
`endif
    endtask

    task automatic test_drain;
        for (int i = 0; i < 16; i++) begin
            pop = 1'b1;
            tick();
            total++; if (pop_valid !== 1'b1 || pop_data !== 8'(i))
                begin bad++; $display("FAIL drain_data i=%0d got v=%b d=%h exp v=1 d=%h", i, pop_valid, pop_data, 8'(i)); end
            total++; if (count !== 5'(15 - i))
                begin bad++; $display("FAIL drain_count got=%0d exp=%0d", count, 15 - i); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
        #1;
        total++; if (ram_rd_en !== 1'b0) begin bad++; $display("FAIL underpop_rd_en got=%b exp=0", ram_rd_en); end
        tick();
        pop = 1'b0;
        total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL underpop_valid got=%b exp=0", pop_valid); end
`ifdef FIFO_ERR_FLAG_EN
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL underflow_set got=%b exp=1", underflow); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (underflow !== 1'b0 || overflow !== 1'b0)
            begin bad++; $display("FAIL err_clr got=%b%b exp=00", overflow, underflow); end
`else
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL underflow_off got=%b exp=0", underflow); end
`endif
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1;
            push_data = 8'(8'hA0 + i);
            tick();
        end
        pop = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_data = 8'(8'hA3 + i);
            tick();
            total++; if (pop_valid !== 1'b1 || pop_data !== 8'(8'hA0 + i))
                begin bad++; $display("FAIL stream_data i=%0d got v=%b d=%h exp v=1 d=%h", i, pop_valid, pop_data, 8'(8'hA0 + i)); end
            total++; if (count !== 5'd3)
                begin bad++; $display("FAIL stream_count i=%0d got=%0d exp=3", i, count); end
        end
        push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pop_valid !== 1'b1 || pop_data !== 8'(8'hC8 + i))
                begin bad++; $display("FAIL stream_tail i=%0d got v=%b d=%h exp v=1 d=%h", i, pop_valid, pop_data, 8'(8'hC8 + i)); end
        end
        pop = 1'b0;
        tick();
        total++; if (empty !== 1'b1 || pop_valid !== 1'b0)
            begin bad++; $display("FAIL stream_end got empty=%b v=%b exp empty=1 v=0", empty, pop_valid); end
    endtask

    task automatic test_full_empty_pushpop;
        for (int i = 0; i < 16; i++) begin
            push = 1'b1;
            push_data = 8'(8'h50 + i);
            tick();
        end
        pop = 1'b1;
        push_data = 8'hFF;
        #1;
        total++; if (ram_wr_en !== 1'b0 || ram_rd_en !== 1'b1)
            begin bad++; $display("FAIL full_pp_en got wr=%b rd=%b exp wr=0 rd=1", ram_wr_en, ram_rd_en); end
        tick();
        push = 1'b0;
        total++; if (pop_valid !== 1'b1 || pop_data !== 8'h50)
            begin bad++; $display("FAIL full_pp_data got v=%b d=%h exp v=1 d=50", pop_valid, pop_data); end
        total++; if (count !== 5'd15 || full !== 1'b0)
            begin bad++; $display("FAIL full_pp_count got=%0d full=%b exp=15 full=0", count, full); end
        for (int i = 1; i < 16; i++) begin
            tick();
            total++; if (pop_valid !== 1'b1 || pop_data !== 8'(8'h50 + i))
                begin bad++; $display("FAIL full_drain i=%0d got d=%h exp d=%h", i, pop_data, 8'(8'h50 + i)); end
        end
        push = 1'b1;
        push_data = 8'h77;
        #1;
        total++; if (ram_wr_en !== 1'b1 || ram_rd_en !== 1'b0)
            begin bad++; $display("FAIL empty_pp_en got wr=%b rd=%b exp wr=1 rd=0", ram_wr_en, ram_rd_en); end
        tick();
        push = 1'b0;
        pop = 1'b0;
        total++; if (pop_valid !== 1'b0 || count !== 5'd1)
            begin bad++; $display("FAIL empty_pp got v=%b count=%0d exp v=0 count=1", pop_valid, count); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        total++; if (pop_valid !== 1'b1 || pop_data !== 8'h77)
            begin bad++; $display("FAIL empty_pp_read got v=%b d=%h exp v=1 d=77", pop_valid, pop_data); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 9; i++) begin
            push = 1'b1;
            push_data = 8'(8'h30 + i);
            tick();
        end
        push = 1'b0;
        total++; if (count !== 5'd9) begin bad++; $display("FAIL mid_pre_count got=%0d exp=9", count); end
        rst = 1'b1;
        pop = 1'b1;
        #1;
        total++; if (ram_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rst_rd_en got=%b exp=0", ram_rd_en); end
        tick();
        rst = 1'b0;
        pop = 1'b0;
        total++; if (count !== 5'd0 || empty !== 1'b1 || pop_valid !== 1'b0)
            begin bad++; $display("FAIL mid_rst got count=%0d empty=%b v=%b exp 0 1 0", count, empty, pop_valid); end
        push = 1'b1;
        push_data = 8'h99;
        tick();
        push = 1'b0;
        pop = 1'b1;
        tick();
        pop = 1'b0;
        total++; if (pop_valid !== 1'b1 || pop_data !== 8'h99)
            begin bad++; $display("FAIL mid_fresh got v=%b d=%h exp v=1 d=99", pop_valid, pop_data); end
        tick();
        total++; if (pop_valid !== 1'b0 || empty !== 1'b1)
            begin bad++; $display("FAIL mid_after got v=%b empty=%b exp v=0 empty=1", pop_valid, empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_empty_pushpop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
